ibex_neur_issue: RTL and testbench
==================================

Name: ibex_neur_issue

Overview:
Initiator side of the mixed-precision neural multiply interface on the Ibex multiplier.
- Accepts one packed 32-bit operand pair per request from the ID/EX stage, at a selected lane precision.
- Unpacks sub-word lanes into four signed 16-bit operand pairs per pass.
- Drives the multiplier's 4-lane dot-product port for 1–4 passes and accumulates the returned partial sums into an internal 32-bit accumulator.
- Returns the accumulator value to the register-file writeback through a valid/ready handshake.

Parameters:
- ACC_W, 32, accumulator and result width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- prec_i  in  2  lane precision: 0=16b (2 lanes), 1=8b (4 lanes), 2=4b (8 lanes), 3=2b (16 lanes)
- op_a_i  in  32  packed activations
- op_b_i  in  32  packed weights
- acc_clr_i  in  1  start this request from 0 instead of the current accumulator value
- flush_i  in  1  abort the in-flight request (pipeline kill)
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  writeback accepts the result
- rsp_data_o  out  32  accumulated result
- neur_mode_o  out  2  mode to the multiplier
- neur_mul_en_o  out  1  multiplier request
- neur_oper_a0_o..neur_oper_a3_o  out  16 each  lane operands A
- neur_oper_b0_o..neur_oper_b3_o  out  16 each  lane operands B
- neur_mul_res_i  in  32  signed 4-lane sum from the multiplier
- neur_mul_valid_i  in  1  multiplier result valid in the same cycle

Behaviour:
- Reset values: state=IDLE, accumulator=0, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, neur_mul_en_o=0, all neur_oper_*=0, neur_mode_o=2'b01.
- neur_mode_o is constant 2'b01, selecting the signed four-lane path. Mode 0 is never driven, because the multiplier treats mode 0 as unsigned/normal.
- Lane k of width w is bits [k*w +: w], sign-extended to 16 bits.
- Passes per request: P = 1, 1, 2, 4 for prec 0..3.
- Pass p feeds lanes 4p..4p+3 to operand slots 0..3.
- For prec 0, slots 0 and 1 carry lanes 0 and 1; slots 2 and 3 are 0.
- States: IDLE, ISSUE, DONE.
  - IDLE: req_ready_o=1. On req_valid_i, latch op_a, op_b and prec, set pass=0, set the accumulator to 0 if acc_clr_i is high, go to ISSUE.
  - ISSUE: neur_mul_en_o=1 with the pass-p operands. If neur_mul_valid_i is high: accumulator += neur_mul_res_i (32-bit two's-complement wrap) and pass increments; after the last pass go to DONE. If neur_mul_valid_i is low, hold state and operands and retry the same pass.
  - DONE: rsp_valid_o=1, rsp_data_o=accumulator, held stable until rsp_ready_i; then go to IDLE.
- Latency with no stalls: acceptance in cycle 0, P ISSUE cycles, response in cycle P+1.
- A new request is accepted only in IDLE; there is no request/response overlap.
- req_ready_o=0 in ISSUE and DONE.
- flush_i in ISSUE or DONE:
  - state goes to IDLE next cycle;
  - accumulator restored to its pre-request value (a snapshot is taken at acceptance);
  - rsp_valid_o drops;
  - flush_i takes priority over a simultaneous rsp_ready_i and over a multiplier valid.
- flush_i in IDLE is ignored and does not block acceptance of a request in the same cycle.
- The accumulator persists across requests until acc_clr_i.
- Reset mid-operation returns every register to its reset value.
- Operand outputs are 0 whenever neur_mul_en_o=0.

Optional Feature:
NEUR_ISSUE_SAT_EN
- Defined: each accumulation saturates to [0x80000000, 0x7FFFFFFF] using a 33-bit sum.
- Undefined: plain 32-bit wrap.

Decomposition:
- Package ibex_neur_issue_pkg holds:
  - prec_e enum (PREC_16/8/4/2);
  - issue state enum;
  - constant NEUR_MODE_SIGNED=2'b01;
  - function passes_for(prec).
- Sub-module ibex_neur_lane_unpack: combinational; inputs op_a, op_b, prec, pass; outputs the eight 16-bit operands.

Test Plan:
- prec=1, a=0x01FF0203, b=0x04040404, acc_clr=1, multiplier always valid → 1 ISSUE cycle, rsp_data=0x00000014 in cycle 2.
- prec=3, a=0xFFFFFFFF, b=0x55555555, acc_clr=1 → 4 passes each returning −4, rsp_data=0xFFFFFFF0.
- prec=2, a=0x77777777, b=0x88888888, acc_clr=1, neur_mul_valid_i low on pass 1 for 3 cycles → operands held, rsp_data=0xFFFFFE40 (−448).
- prec=0, a=0x80007FFF, b=0x00020002, acc_clr=0 with prior acc=10 → rsp_data=8; slots 2 and 3 are 0.
- Accumulator=0x7FFFFFF0 plus the prec=1 case above (+20) → 0x7FFFFFFF with NEUR_ISSUE_SAT_EN, 0x80000004 without.
- flush_i during pass 2 of a prec=3 request with prior acc=5 → IDLE next cycle, no rsp_valid, next acc_clr=0 request sees acc=5.

Source files
------------

// File: rtl/ibex_neur_issue_pkg.sv
// ibex_neur_issue_pkg
//   Shared types and constants for the neural multiply initiator:
//   lane precision encoding, issue FSM states, the multiplier mode
//   constant and the pass-count helper.
package ibex_neur_issue_pkg;

  // Lane precision as seen on prec_i.
  typedef enum logic [1:0] {
    PREC_16 = 2'd0,  // 2 lanes of 16 bits
    PREC_8  = 2'd1,  // 4 lanes of 8 bits
    PREC_4  = 2'd2,  // 8 lanes of 4 bits
    PREC_2  = 2'd3   // 16 lanes of 2 bits
  } prec_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } issue_state_e;

  // Signed four-lane dot-product path. Mode 0 would select the unsigned path.
  localparam logic [1:0] NEUR_MODE_SIGNED = 2'b01;

  // Number of 4-slot multiplier passes needed to cover every lane.
  function automatic logic [2:0] passes_for(prec_e prec);
    logic [2:0] n;
    unique case (prec)
      PREC_16: n = 3'd1;
      PREC_8:  n = 3'd1;
      PREC_4:  n = 3'd2;
      PREC_2:  n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ibex_neur_lane_unpack.sv
// ibex_neur_lane_unpack
//   Combinational lane extractor. Selects the four lanes belonging to the
//   current pass from the packed operands and sign-extends each to 16 bits.
// Ports:
//   op_a_i, op_b_i  packed activations / weights
//   prec_i          lane precision
//   pass_i          pass index (lanes 4*pass .. 4*pass+3)
//   oper_a*_o, oper_b*_o  slot operands 0..3
module ibex_neur_lane_unpack
  import ibex_neur_issue_pkg::*;
(
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  prec_e       prec_i,
  input  logic [1:0]  pass_i,
  output logic [15:0] oper_a0_o,
  output logic [15:0] oper_a1_o,
  output logic [15:0] oper_a2_o,
  output logic [15:0] oper_a3_o,
  output logic [15:0] oper_b0_o,
  output logic [15:0] oper_b1_o,
  output logic [15:0] oper_b2_o,
  output logic [15:0] oper_b3_o
);

  logic [15:0] slot_a [4];
  logic [15:0] slot_b [4];
  // Operands shifted so the current pass's lanes sit at bit 0.
  logic [15:0] a_sh;
  logic [15:0] b_sh;

  always_comb begin
    for (int unsigned s = 0; s < 4; s++) begin
      slot_a[s] = '0;
      slot_b[s] = '0;
    end
    a_sh = '0;
    b_sh = '0;
    unique case (prec_i)
      PREC_16: begin
        // Only two lanes exist; slots 2 and 3 stay zero.
        slot_a[0] = op_a_i[15:0];
        slot_a[1] = op_a_i[31:16];
        slot_b[0] = op_b_i[15:0];
        slot_b[1] = op_b_i[31:16];
      end
      PREC_8: begin
        for (int unsigned s = 0; s < 4; s++) begin
          slot_a[s] = {{8{op_a_i[8*s+7]}}, op_a_i[8*s +: 8]};
          slot_b[s] = {{8{op_b_i[8*s+7]}}, op_b_i[8*s +: 8]};
        end
      end
      PREC_4: begin
        // Each pass consumes 16 bits of each operand.
        a_sh = 16'(op_a_i >> {pass_i, 4'b0000});
        b_sh = 16'(op_b_i >> {pass_i, 4'b0000});
        for (int unsigned s = 0; s < 4; s++) begin
          slot_a[s] = {{12{a_sh[4*s+3]}}, a_sh[4*s +: 4]};
          slot_b[s] = {{12{b_sh[4*s+3]}}, b_sh[4*s +: 4]};
        end
      end
      PREC_2: begin
        // Each pass consumes 8 bits of each operand.
        a_sh = 16'(op_a_i >> {pass_i, 3'b000});
        b_sh = 16'(op_b_i >> {pass_i, 3'b000});
        for (int unsigned s = 0; s < 4; s++) begin
          slot_a[s] = {{14{a_sh[2*s+1]}}, a_sh[2*s +: 2]};
          slot_b[s] = {{14{b_sh[2*s+1]}}, b_sh[2*s +: 2]};
        end
      end
      default: ;
    endcase
  end

  assign oper_a0_o = slot_a[0];
  assign oper_a1_o = slot_a[1];
  assign oper_a2_o = slot_a[2];
  assign oper_a3_o = slot_a[3];
  assign oper_b0_o = slot_b[0];
  assign oper_b1_o = slot_b[1];
  assign oper_b2_o = slot_b[2];
  assign oper_b3_o = slot_b[3];

endmodule

// File: rtl/ibex_neur_issue.sv
// ibex_neur_issue
//   Initiator side of the mixed-precision neural multiply interface.
//   Accepts a packed operand pair, drives the 4-lane signed dot-product port
//   for 1-4 passes, accumulates the partial sums and returns the accumulator
//   through a valid/ready response.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   req_valid_i/req_ready_o          request handshake (accepted in IDLE only)
//   prec_i, op_a_i, op_b_i, acc_clr_i  request payload
//   flush_i                          abort in-flight request, restore accumulator
//   rsp_valid_o/rsp_ready_i/rsp_data_o response handshake
//   neur_*                           multiplier dot-product port
// Configuration:
//   NEUR_ISSUE_SAT_EN  when defined, each accumulation saturates to the
//                      signed 32-bit range instead of wrapping.
module ibex_neur_issue
  import ibex_neur_issue_pkg::*;
#(
  parameter int unsigned ACC_W = 32  // only 32 supported
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       prec_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic             acc_clr_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [ACC_W-1:0] rsp_data_o,
  output logic [1:0]       neur_mode_o,
  output logic             neur_mul_en_o,
  output logic [15:0]      neur_oper_a0_o,
  output logic [15:0]      neur_oper_a1_o,
  output logic [15:0]      neur_oper_a2_o,
  output logic [15:0]      neur_oper_a3_o,
  output logic [15:0]      neur_oper_b0_o,
  output logic [15:0]      neur_oper_b1_o,
  output logic [15:0]      neur_oper_b2_o,
  output logic [15:0]      neur_oper_b3_o,
  input  logic [31:0]      neur_mul_res_i,
  input  logic             neur_mul_valid_i
);

  issue_state_e     state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] snap_q;    // accumulator before the in-flight request
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  prec_e            prec_q;
  logic [1:0]       pass_q;

  logic             issuing;
  logic             last_pass;
  logic [ACC_W-1:0] acc_sum;
  logic [15:0]      slot_a0, slot_a1, slot_a2, slot_a3;
  logic [15:0]      slot_b0, slot_b1, slot_b2, slot_b3;

  assign issuing   = (state_q == ST_ISSUE);
  assign last_pass = ({1'b0, pass_q} == (passes_for(prec_q) - 3'd1));

`ifdef NEUR_ISSUE_SAT_EN
  // A 33-bit signed sum overflows exactly when its top two bits differ.
  logic [ACC_W:0] wide_sum;
  assign wide_sum = {acc_q[ACC_W-1], acc_q} + {neur_mul_res_i[31], neur_mul_res_i};
  always_comb begin
    if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
      acc_sum = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_sum = wide_sum[ACC_W-1:0];
    end
  end
`else
  assign acc_sum = acc_q + neur_mul_res_i;
`endif

  ibex_neur_lane_unpack u_unpack (
    .op_a_i    (op_a_q),
    .op_b_i    (op_b_q),
    .prec_i    (prec_q),
    .pass_i    (pass_q),
    .oper_a0_o (slot_a0),
    .oper_a1_o (slot_a1),
    .oper_a2_o (slot_a2),
    .oper_a3_o (slot_a3),
    .oper_b0_o (slot_b0),
    .oper_b1_o (slot_b1),
    .oper_b2_o (slot_b2),
    .oper_b3_o (slot_b3)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      snap_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prec_q  <= PREC_16;
      pass_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // flush_i has no effect here.
          if (req_valid_i) begin
            op_a_q <= op_a_i;
            op_b_q <= op_b_i;
            prec_q <= prec_e'(prec_i);
            pass_q <= '0;
            snap_q <= acc_q;
            if (acc_clr_i) acc_q <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (flush_i) begin
            acc_q   <= snap_q;
            state_q <= ST_IDLE;
          end else if (neur_mul_valid_i) begin
            acc_q <= acc_sum;
            if (last_pass) begin
              state_q <= ST_DONE;
            end else begin
              pass_q <= pass_q + 2'd1;
            end
          end
        end
        ST_DONE: begin
          if (flush_i) begin
            acc_q   <= snap_q;
            state_q <= ST_IDLE;
          end else if (rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign rsp_valid_o   = (state_q == ST_DONE);
  assign rsp_data_o    = (state_q == ST_DONE) ? acc_q : '0;
  assign neur_mode_o   = NEUR_MODE_SIGNED;
  assign neur_mul_en_o = issuing;

  assign neur_oper_a0_o = issuing ? slot_a0 : '0;
  assign neur_oper_a1_o = issuing ? slot_a1 : '0;
  assign neur_oper_a2_o = issuing ? slot_a2 : '0;
  assign neur_oper_a3_o = issuing ? slot_a3 : '0;
  assign neur_oper_b0_o = issuing ? slot_b0 : '0;
  assign neur_oper_b1_o = issuing ? slot_b1 : '0;
  assign neur_oper_b2_o = issuing ? slot_b2 : '0;
  assign neur_oper_b3_o = issuing ? slot_b3 : '0;

endmodule

// File: tb/tb_ibex_neur_issue.sv
// tb_ibex_neur_issue
//   Self-checking bench for ibex_neur_issue. Acts as the multiplier
//   (combinational 4-lane signed dot product) and compares the issued
//   operands and returned accumulator against a lane-level reference model.
module tb_ibex_neur_issue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  prec_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        acc_clr_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [1:0]  neur_mode_o;
  logic        neur_mul_en_o;
  logic [15:0] neur_oper_a0_o, neur_oper_a1_o, neur_oper_a2_o, neur_oper_a3_o;
  logic [15:0] neur_oper_b0_o, neur_oper_b1_o, neur_oper_b2_o, neur_oper_b3_o;
  logic [31:0] neur_mul_res_i;
  logic        neur_mul_valid_i;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_acc = '0;
  logic [31:0] last_result = '0;

  ibex_neur_issue #(.ACC_W(32)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .prec_i           (prec_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .acc_clr_i        (acc_clr_i),
    .flush_i          (flush_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .neur_mode_o      (neur_mode_o),
    .neur_mul_en_o    (neur_mul_en_o),
    .neur_oper_a0_o   (neur_oper_a0_o),
    .neur_oper_a1_o   (neur_oper_a1_o),
    .neur_oper_a2_o   (neur_oper_a2_o),
    .neur_oper_a3_o   (neur_oper_a3_o),
    .neur_oper_b0_o   (neur_oper_b0_o),
    .neur_oper_b1_o   (neur_oper_b1_o),
    .neur_oper_b2_o   (neur_oper_b2_o),
    .neur_oper_b3_o   (neur_oper_b3_o),
    .neur_mul_res_i   (neur_mul_res_i),
    .neur_mul_valid_i (neur_mul_valid_i)
  );

  always #5 clk_i = ~clk_i;

  // Multiplier: signed 4-lane dot product of whatever the DUT presents.
  always_comb begin
    int pa0, pa1, pa2, pa3, pb0, pb1, pb2, pb3;
    pa0 = $signed(neur_oper_a0_o); pb0 = $signed(neur_oper_b0_o);
    pa1 = $signed(neur_oper_a1_o); pb1 = $signed(neur_oper_b1_o);
    pa2 = $signed(neur_oper_a2_o); pb2 = $signed(neur_oper_b2_o);
    pa3 = $signed(neur_oper_a3_o); pb3 = $signed(neur_oper_b3_o);
    neur_mul_res_i = 32'(pa0 * pb0 + pa1 * pb1 + pa2 * pb2 + pa3 * pb3);
  end

  // ---------------- reference model ----------------
  function automatic int lane_width(input logic [1:0] prec);
    return 16 >> prec;
  endfunction

  function automatic int num_passes(input logic [1:0] prec);
    int nl;
    nl = 32 / lane_width(prec);
    return (nl + 3) / 4;
  endfunction

  // Signed value of lane (4*p + s), or 0 when that lane does not exist.
  function automatic int lane_val(input logic [1:0] prec, input logic [31:0] op,
                                  input int p, input int s);
    int w, k, v;
    logic [31:0] field;
    w = lane_width(prec);
    k = 4 * p + s;
    if (k >= 32 / w) return 0;
    field = (op >> (k * w)) & ((33'd1 << w) - 33'd1);
    v = int'(field);
    if (v >= (1 << (w - 1))) v = v - (1 << w);
    return v;
  endfunction

  function automatic logic [127:0] exp_ops(input logic [1:0] prec, input logic [31:0] a,
                                           input logic [31:0] b, input int p);
    logic [127:0] r;
    for (int s = 0; s < 4; s++) begin
      r[16*(7-s) +: 16] = 16'(lane_val(prec, a, p, s));
      r[16*(3-s) +: 16] = 16'(lane_val(prec, b, p, s));
    end
    return r;
  endfunction

  function automatic logic [31:0] pass_sum(input logic [1:0] prec, input logic [31:0] a,
                                           input logic [31:0] b, input int p);
    int sum;
    sum = 0;
    for (int s = 0; s < 4; s++) sum += lane_val(prec, a, p, s) * lane_val(prec, b, p, s);
    return 32'(sum);
  endfunction

  function automatic logic [31:0] acc_add(input logic [31:0] acc, input logic [31:0] s);
`ifdef NEUR_ISSUE_SAT_EN
    longint t;
    t = longint'($signed(acc)) + longint'($signed(s));
    if (t > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (t < -64'sh80000000) return 32'h80000000;
    return t[31:0];
`else
    return acc + s;
`endif
  endfunction

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_ni = 1'b0; req_valid_i = 0; flush_i = 0; rsp_ready_i = 0;
    neur_mul_valid_i = 0; acc_clr_i = 0; prec_i = 0; op_a_i = 0; op_b_i = 0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_acc = '0;
  endtask

  // Runs one request. flush_at: pass index to flush in, num_passes = flush in
  // DONE, -1 = no flush. stall_pass/stall_n force extra invalid cycles.
  task automatic do_req(input logic [1:0] prec, input logic [31:0] a, input logic [31:0] b,
                        input bit clr, input int stall_pct, input int stall_pass,
                        input int stall_n, input int flush_at, input int hold_max);
    int np, p, cyc, forced, holds;
    logic [31:0] exp_acc;
    logic [127:0] ops;
    np = num_passes(prec);
    exp_acc = clr ? 32'h0 : model_acc;
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++; $display("FAIL idle_ready: got %b want 1", req_ready_o);
    end
    req_valid_i = 1; prec_i = prec; op_a_i = a; op_b_i = b; acc_clr_i = clr;
    flush_i = 1'($urandom_range(0, 1));  // must be ignored in IDLE
    @(posedge clk_i); #1;
    req_valid_i = 0; flush_i = 0; acc_clr_i = 1'($urandom);
    op_a_i = $urandom; op_b_i = $urandom; prec_i = 2'($urandom);
    p = 0; cyc = 0; forced = 0;
    while (p < np) begin
      if (cyc >= 64) begin
        total++; bad++;
        $display("FAIL issue_timeout: pass %0d never completed", p);
        do_reset();
        return;
      end
      ops = {neur_oper_a0_o, neur_oper_a1_o, neur_oper_a2_o, neur_oper_a3_o,
             neur_oper_b0_o, neur_oper_b1_o, neur_oper_b2_o, neur_oper_b3_o};
      total++;
      if ({neur_mul_en_o, req_ready_o, rsp_valid_o, neur_mode_o} !== 5'b10001) begin
        bad++; $display("FAIL issue_ctrl: en/rdy/vld/mode=%b want 10001",
                        {neur_mul_en_o, req_ready_o, rsp_valid_o, neur_mode_o});
      end
      total++;
      if (ops !== exp_ops(prec, a, b, p)) begin
        bad++; $display("FAIL operands pass %0d: got %h want %h", p, ops, exp_ops(prec, a, b, p));
      end
      if (p == flush_at) begin
        flush_i = 1; neur_mul_valid_i = 1'($urandom);
        @(posedge clk_i); #1;
        flush_i = 0; neur_mul_valid_i = 0;
        total++;
        if ({req_ready_o, rsp_valid_o, neur_mul_en_o} !== 3'b100) begin
          bad++; $display("FAIL flush_issue: rdy/vld/en=%b want 100",
                          {req_ready_o, rsp_valid_o, neur_mul_en_o});
        end
        return;
      end
      neur_mul_valid_i = ($urandom_range(0, 99) >= stall_pct);
      if (p == stall_pass && forced < stall_n) begin
        neur_mul_valid_i = 0; forced++;
      end
      @(posedge clk_i); #1;
      if (neur_mul_valid_i) begin
        exp_acc = acc_add(exp_acc, pass_sum(prec, a, b, p));
        p++;
      end
      neur_mul_valid_i = 0;
      cyc++;
    end
    if (stall_pct == 0 && stall_n == 0) begin
      total++;
      if (cyc !== np) begin
        bad++; $display("FAIL latency: issue cycles %0d want %0d", cyc, np);
      end
    end
    total++;
    if ({rsp_valid_o, req_ready_o, neur_mul_en_o, rsp_data_o} !== {3'b100, exp_acc}) begin
      bad++; $display("FAIL done_rsp: vld/rdy/en=%b data=%h want 100 %h",
                      {rsp_valid_o, req_ready_o, neur_mul_en_o}, rsp_data_o, exp_acc);
    end
    total++;
    if ({neur_oper_a0_o, neur_oper_b0_o, neur_oper_a3_o, neur_oper_b3_o} !== 64'h0) begin
      bad++; $display("FAIL idle_operands: got %h want 0",
                      {neur_oper_a0_o, neur_oper_b0_o, neur_oper_a3_o, neur_oper_b3_o});
    end
    holds = $urandom_range(0, hold_max);
    repeat (holds) begin
      @(posedge clk_i); #1;
      total++;
      if ({rsp_valid_o, rsp_data_o} !== {1'b1, exp_acc}) begin
        bad++; $display("FAIL rsp_hold: vld=%b data=%h want 1 %h", rsp_valid_o, rsp_data_o, exp_acc);
      end
    end
    if (flush_at == np) begin
      flush_i = 1; rsp_ready_i = 1;  // flush wins over rsp_ready
      @(posedge clk_i); #1;
      flush_i = 0; rsp_ready_i = 0;
      total++;
      if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
        bad++; $display("FAIL flush_done: rdy/vld=%b want 10", {req_ready_o, rsp_valid_o});
      end
      return;
    end
    rsp_ready_i = 1;
    @(posedge clk_i); #1;
    rsp_ready_i = 0;
    total++;
    if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
      bad++; $display("FAIL rsp_accept: rdy/vld=%b want 10", {req_ready_o, rsp_valid_o});
    end
    model_acc   = exp_acc;
    last_result = exp_acc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 0; flush_i = 0; rsp_ready_i = 0;
    neur_mul_valid_i = 0; acc_clr_i = 0; prec_i = 0; op_a_i = 0; op_b_i = 0;
    #3;
    total++;
    if ({req_ready_o, rsp_valid_o, neur_mul_en_o, neur_mode_o, rsp_data_o} !== {5'b10001, 32'h0}) begin
      bad++; $display("FAIL reset_outputs: got %b_%h want 10001_0",
                      {req_ready_o, rsp_valid_o, neur_mul_en_o, neur_mode_o}, rsp_data_o);
    end
    total++;
    if ({neur_oper_a0_o, neur_oper_a1_o, neur_oper_a2_o, neur_oper_a3_o,
         neur_oper_b0_o, neur_oper_b1_o, neur_oper_b2_o, neur_oper_b3_o} !== 128'h0) begin
      bad++; $display("FAIL reset_operands: nonzero operand");
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_acc = '0;
    // Reset accumulator must read back as 0 through a no-clear zero request.
    do_req(2'd1, 32'h0, 32'h0, 1'b0, 0, -1, 0, -1, 0);
    total++;
    if (last_result !== 32'h0) begin
      bad++; $display("FAIL reset_acc: got %h want 0", last_result);
    end
  endtask

  task automatic test_prec8();
    do_req(2'd1, 32'h01FF0203, 32'h04040404, 1'b1, 0, -1, 0, -1, 2);
    total++;
    if (last_result !== 32'h00000014) begin
      bad++; $display("FAIL prec8_result: got %h want 00000014", last_result);
    end
  endtask

  task automatic test_prec2();
    do_req(2'd3, 32'hFFFFFFFF, 32'h55555555, 1'b1, 0, -1, 0, -1, 1);
    total++;
    if (last_result !== 32'hFFFFFFF0) begin
      bad++; $display("FAIL prec2_result: got %h want FFFFFFF0", last_result);
    end
  endtask

  task automatic test_prec4_stall();
    do_req(2'd2, 32'h77777777, 32'h88888888, 1'b1, 0, 1, 3, -1, 0);
    total++;
    if (last_result !== 32'hFFFFFE40) begin
      bad++; $display("FAIL prec4_stall_result: got %h want FFFFFE40", last_result);
    end
  endtask

  task automatic test_prec16();
    do_req(2'd1, 32'h0000000A, 32'h00000001, 1'b1, 0, -1, 0, -1, 0);
    do_req(2'd0, 32'h80007FFF, 32'h00020002, 1'b0, 0, -1, 0, -1, 0);
    total++;
    if (last_result !== 32'h00000008) begin
      bad++; $display("FAIL prec16_result: got %h want 00000008", last_result);
    end
  endtask

  task automatic test_sat();
    do_req(2'd0, 32'h7FFF7FFF, 32'h7FFF7FFF, 1'b1, 0, -1, 0, -1, 0);
    do_req(2'd0, 32'h0000000E, 32'h00002491, 1'b0, 0, -1, 0, -1, 0);
    total++;
    if (last_result !== 32'h7FFFFFF0) begin
      bad++; $display("FAIL sat_setup: got %h want 7FFFFFF0", last_result);
    end
    do_req(2'd1, 32'h01FF0203, 32'h04040404, 1'b0, 0, -1, 0, -1, 0);
    total++;
`ifdef NEUR_ISSUE_SAT_EN
    if (last_result !== 32'h7FFFFFFF) begin
      bad++; $display("FAIL sat_result: got %h want 7FFFFFFF", last_result);
    end
`else
    if (last_result !== 32'h80000004) begin
      bad++; $display("FAIL wrap_result: got %h want 80000004", last_result);
    end
`endif
  endtask

  task automatic test_flush();
    do_req(2'd1, 32'h00000005, 32'h00000001, 1'b1, 0, -1, 0, -1, 0);
    do_req(2'd3, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0, -1, 0, 2, 0);
    do_req(2'd1, 32'h00000000, 32'h00000000, 1'b0, 0, -1, 0, -1, 0);
    total++;
    if (last_result !== 32'h00000005) begin
      bad++; $display("FAIL flush_restore: got %h want 00000005", last_result);
    end
    // Flush of a clearing request in DONE must also restore the old value.
    do_req(2'd1, 32'h01010101, 32'h01010101, 1'b1, 0, -1, 0, 1, 0);
    do_req(2'd1, 32'h00000000, 32'h00000000, 1'b0, 0, -1, 0, -1, 0);
    total++;
    if (last_result !== 32'h00000005) begin
      bad++; $display("FAIL flush_done_restore: got %h want 00000005", last_result);
    end
  endtask

  task automatic test_reset_mid();
    do_req(2'd1, 32'h00000007, 32'h00000001, 1'b1, 0, -1, 0, -1, 0);
    req_valid_i = 1; prec_i = 2'd3; op_a_i = $urandom; op_b_i = $urandom; acc_clr_i = 0;
    @(posedge clk_i); #1;
    req_valid_i = 0; neur_mul_valid_i = 1;
    @(posedge clk_i); #1;
    neur_mul_valid_i = 0;
    rst_ni = 1'b0;
    #2;
    total++;
    if ({req_ready_o, rsp_valid_o, neur_mul_en_o, neur_oper_a0_o, neur_oper_b1_o} !== {3'b100, 32'h0}) begin
      bad++; $display("FAIL reset_mid_outputs: got %b %h want 100 0",
                      {req_ready_o, rsp_valid_o, neur_mul_en_o}, {neur_oper_a0_o, neur_oper_b1_o});
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_acc = '0;
    do_req(2'd1, 32'h0, 32'h0, 1'b0, 0, -1, 0, -1, 0);
    total++;
    if (last_result !== 32'h0) begin
      bad++; $display("FAIL reset_mid_acc: got %h want 0", last_result);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [1:0] pr;
      int fl;
      pr = 2'($urandom);
      fl = ($urandom_range(0, 99) < 15) ? $urandom_range(0, num_passes(pr)) : -1;
      do_req(pr, $urandom, $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 50),
             -1, 0, fl, 3);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      do_req(2'($urandom), $urandom, $urandom, 1'($urandom), 0, -1, 0, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_prec8();
    test_prec2();
    test_prec4_stall();
    test_prec16();
    test_sat();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
